// File: rtl/ram_rr_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port ram.
// master: the requester/ram side (testbench or surrounding datapath).
// slave : the arbiter itself.
interface ram_rr_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    // requester A
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_adr;
    logic [DW-1:0] a_din;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;
    // requester B
    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_adr;
    logic [DW-1:0] b_din;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;
    // ram side
    logic          ram_we;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    // status
    logic          busy;

    modport master (
        output a_req, a_we, a_adr, a_din,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_adr, b_din,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_we, ram_adr, ram_din,
        output ram_dout,
        input  busy
    );

    modport slave (
        input  a_req, a_we, a_adr, a_din,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_adr, b_din,
        output b_gnt, b_rvalid, b_rdata,
        output ram_we, ram_adr, ram_din,
        input  ram_dout,
        output busy
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Two-way round-robin arbiter/sequencer in front of one single-port ram.
// IDLE grants one requester (combinational gnt), ACCESS drives the ram for
// one cycle, WAIT covers the ram read latency and returns the read data.

// Per-requester read return: holds the last read result and presents the
// live ram data during the completing cycle so rvalid/rdata line up.
module ram_rr_arbiter_port #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          done_i,
    input  logic [DW-1:0] ram_dout_i,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] rdata_q;

    // capture the returning word at the end of the completing cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rdata_q <= '0;
        else if (done_i) rdata_q <= ram_dout_i;
    end

    assign rvalid_o = done_i;
    assign rdata_o  = done_i ? ram_dout_i : rdata_q;
endmodule

module ram_rr_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input logic             clk,
    input logic             rst_n,
    ram_rr_arbiter_if.slave bus
);
    localparam int NREQ = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    // WAIT lasts RD_LAT cycles; counter runs 0..RD_LAT-1
    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          ptr_q, ptr_d;     // 0 = A has priority, 1 = B
    logic          own_q, own_d;     // owner of the in-flight access
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] din_q, din_d;

    logic                      idle;
    logic                      sel_b;
    logic [NREQ-1:0]           gnt;
    logic                      done;
    logic [NREQ-1:0]           done_vec;
    logic [NREQ-1:0]           rvalid;
    logic [NREQ-1:0][DW-1:0]   rdata;

    assign idle = (state_q == S_IDLE);

    // B wins if it is the only requester, or both request and ptr points at B.
    // Gating with rst_n keeps gnt low while reset is asserted.
    assign sel_b  = bus.b_req & (~bus.a_req | ptr_q);
    assign gnt[0] = rst_n & idle & bus.a_req & ~sel_b;
    assign gnt[1] = rst_n & idle & sel_b;

    // state sequencing: IDLE -> ACCESS -> (WAIT x RD_LAT) -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|gnt) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) state_d = S_IDLE;
                else                   cnt_d   = cnt_q + 2'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // latch the winning request and hand priority to the other side
    always_comb begin
        we_d  = we_q;
        adr_d = adr_q;
        din_d = din_q;
        own_d = own_q;
        ptr_d = ptr_q;
        if (|gnt) begin
            we_d  = sel_b ? bus.b_we  : bus.a_we;
            adr_d = sel_b ? bus.b_adr : bus.a_adr;
            din_d = sel_b ? bus.b_din : bus.a_din;
            own_d = sel_b;
            ptr_d = ~sel_b;
        end
    end

    // state, counter and request latch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            din_q   <= din_d;
        end
    end

    // last WAIT cycle: ram_dout is valid for the owner
    assign done        = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
    assign done_vec[0] = done & ~own_q;
    assign done_vec[1] = done &  own_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_port
        ram_rr_arbiter_port #(.DW(DW)) u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .done_i     (done_vec[g]),
            .ram_dout_i (bus.ram_dout),
            .rvalid_o   (rvalid[g]),
            .rdata_o    (rdata[g])
        );
    end

    // ram address/data come straight from the latch, so they hold their
    // last value outside ACCESS; the write strobe is ACCESS-only
    assign bus.ram_we  = (state_q == S_ACCESS) & we_q;
    assign bus.ram_adr = adr_q;
    assign bus.ram_din = din_q;

    assign bus.a_gnt    = gnt[0];
    assign bus.b_gnt    = gnt[1];
    assign bus.a_rvalid = rvalid[0];
    assign bus.b_rvalid = rvalid[1];
    assign bus.a_rdata  = rdata[0];
    assign bus.b_rdata  = rdata[1];
    assign bus.busy     = ~idle;
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: directed scenarios on an RD_LAT=1 instance and an
// RD_LAT=3 instance, plus a randomized run against a transaction-level model.
module tb_ram_rr_arbiter;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter_if #(.AW(AW), .DW(DW)) bus  ();
    ram_rr_arbiter_if #(.AW(AW), .DW(DW)) bus3 ();

    ram_rr_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    ram_rr_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    // ram behaviour: synchronous write, read data RD_LAT edges after ACCESS
    logic [DW-1:0] mem  [0:255];
    logic [DW-1:0] mem3 [0:255];
    logic [DW-1:0] p1, p3a, p3b, p3c;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_adr] <= bus.ram_din;
        p1 <= mem[bus.ram_adr];
        if (bus3.ram_we) mem3[bus3.ram_adr] <= bus3.ram_din;
        p3a <= mem3[bus3.ram_adr];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign bus.ram_dout  = p1;
    assign bus3.ram_dout = p3c;

    task automatic idle_inputs;
        bus.a_req = 0; bus.a_we = 0; bus.a_adr = '0; bus.a_din = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_adr = '0; bus.b_din = '0;
        bus3.a_req = 0; bus3.a_we = 0; bus3.a_adr = '0; bus3.a_din = '0;
        bus3.b_req = 0; bus3.b_we = 0; bus3.b_adr = '0; bus3.b_din = '0;
    endtask

    task automatic do_reset;
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset;
        logic [7:0] flags;
        rst_n = 0;
        bus.a_req = 1; bus.a_we = 1; bus.a_adr = 8'h11; bus.a_din = 32'hdead;
        bus.b_req = 1; bus.b_we = 0; bus.b_adr = 8'h22; bus.b_din = 32'hbeef;
        #1;
        flags = {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.ram_we, bus.busy, 2'b00};
        total++; if (flags !== 8'h00 || bus.a_rdata !== '0 || bus.b_rdata !== '0 || bus.ram_adr !== '0 || bus.ram_din !== '0) begin
            bad++; $display("FAIL reset_outputs: flags=%b adr=%h din=%h rd=%h/%h want all 0", flags, bus.ram_adr, bus.ram_din, bus.a_rdata, bus.b_rdata); end
        // release, grant an A write, then pull reset during its ACCESS
        @(negedge clk); rst_n = 1; bus.b_req = 0; bus.a_adr = 8'd6; bus.a_din = 32'd77; #1;
        total++; if (bus.a_gnt !== 1'b1) begin bad++; $display("FAIL reset_first_gnt: got %b want 1", bus.a_gnt); end
        @(negedge clk); bus.a_req = 0; #1;
        total++; if (bus.ram_we !== 1'b1) begin bad++; $display("FAIL reset_pre_access: ram_we got %b want 1", bus.ram_we); end
        bus.a_req = 1; bus.b_req = 1; #1; rst_n = 0; #1;
        flags = {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.ram_we, bus.busy, 2'b00};
        total++; if (flags !== 8'h00 || bus.ram_adr !== '0 || bus.ram_din !== '0) begin
            bad++; $display("FAIL reset_mid_access: flags=%b adr=%h din=%h want all 0", flags, bus.ram_adr, bus.ram_din); end
    endtask

    task automatic test_write_read;
        do_reset();
        @(negedge clk); bus.a_req = 1; bus.a_we = 1; bus.a_adr = 8'd1; bus.a_din = 32'd50; #1;
        total++; if ({bus.a_gnt, bus.b_gnt, bus.ram_we} !== 3'b100) begin bad++; $display("FAIL wr_gnt: got %b want 100", {bus.a_gnt, bus.b_gnt, bus.ram_we}); end
        @(negedge clk); bus.a_req = 0; #1;
        total++; if ({bus.ram_we, bus.a_gnt, bus.busy} !== 3'b101 || bus.ram_adr !== 8'd1 || bus.ram_din !== 32'd50) begin
            bad++; $display("FAIL wr_access: we/gnt/busy=%b adr=%0d din=%0d want 101 1 50", {bus.ram_we, bus.a_gnt, bus.busy}, bus.ram_adr, bus.ram_din); end
        @(negedge clk); #1;
        total++; if ({bus.ram_we, bus.busy} !== 2'b00 || bus.ram_adr !== 8'd1) begin bad++; $display("FAIL wr_after: we/busy=%b adr=%0d want 00 1", {bus.ram_we, bus.busy}, bus.ram_adr); end
        @(negedge clk); bus.a_req = 1; bus.a_we = 0; bus.a_adr = 8'd1; #1;
        total++; if (bus.a_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt: got %b want 1", bus.a_gnt); end
        for (int k = 1; k <= 1 + LAT; k++) begin
            @(negedge clk); bus.a_req = 0; #1;
            total++; if ({bus.a_rvalid, bus.ram_we, bus.busy} !== {(k == 1 + LAT), 1'b0, 1'b1}) begin
                bad++; $display("FAIL rd_cycle%0d: rvalid/we/busy=%b want %b", k, {bus.a_rvalid, bus.ram_we, bus.busy}, {(k == 1 + LAT), 2'b01}); end
            if (k == 1 + LAT) begin
                total++; if (bus.a_rdata !== 32'd50) begin bad++; $display("FAIL rd_data: got %0d want 50", bus.a_rdata); end
            end
        end
        @(negedge clk); #1;
        total++; if ({bus.a_rvalid, bus.busy} !== 2'b00 || bus.a_rdata !== 32'd50) begin
            bad++; $display("FAIL rd_hold: rvalid/busy=%b rdata=%0d want 00 50", {bus.a_rvalid, bus.busy}, bus.a_rdata); end
    endtask

    task automatic test_both_writes;
        logic [3:0] exp_v;
        do_reset();
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 1; bus.a_adr = 8'd2; bus.a_din = 32'd2;
        bus.b_req = 1; bus.b_we = 1; bus.b_adr = 8'd3; bus.b_din = 32'd7; #1;
        total++; if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin bad++; $display("FAIL both_first: got %b want 10", {bus.a_gnt, bus.b_gnt}); end
        @(negedge clk); bus.a_req = 0; #1;
        total++; if ({bus.a_gnt, bus.b_gnt, bus.ram_we} !== 3'b001 || bus.ram_adr !== 8'd2 || bus.ram_din !== 32'd2) begin
            bad++; $display("FAIL both_a_access: g/we=%b adr=%0d din=%0d want 001 2 2", {bus.a_gnt, bus.b_gnt, bus.ram_we}, bus.ram_adr, bus.ram_din); end
        @(negedge clk); #1;
        total++; if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin bad++; $display("FAIL both_second: got %b want 01", {bus.a_gnt, bus.b_gnt}); end
        @(negedge clk); bus.b_req = 0; #1;
        total++; if (bus.ram_we !== 1'b1 || bus.ram_adr !== 8'd3 || bus.ram_din !== 32'd7) begin
            bad++; $display("FAIL both_b_access: we=%b adr=%0d din=%0d want 1 3 7", bus.ram_we, bus.ram_adr, bus.ram_din); end
        // read both back: A first (ptr returned to A), B after A's read completes
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 0; bus.a_adr = 8'd2;
        bus.b_req = 1; bus.b_we = 0; bus.b_adr = 8'd3; #1;
        total++; if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin bad++; $display("FAIL rb_first: got %b want 10", {bus.a_gnt, bus.b_gnt}); end
        for (int k = 1; k <= 3 + 2 * LAT; k++) begin
            @(negedge clk);
            bus.a_req = 0;
            if (k == 3 + LAT) bus.b_req = 0;
            #1;
            exp_v = {1'b0, (k == 2 + LAT), (k == 1 + LAT), (k == 3 + 2 * LAT)};
            total++; if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid} !== exp_v) begin
                bad++; $display("FAIL rb_cycle%0d: gnt/rvalid=%b want %b", k, {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid}, exp_v); end
        end
        total++; if (bus.a_rdata !== 32'd2 || bus.b_rdata !== 32'd7) begin
            bad++; $display("FAIL rb_data: a=%0d b=%0d want 2 7", bus.a_rdata, bus.b_rdata); end
        @(negedge clk); #1;
    endtask

    task automatic test_alternation;
        logic [1:0] exp_g;
        do_reset();
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 1; bus.a_adr = 8'd8; bus.a_din = 32'd100;
        bus.b_req = 1; bus.b_we = 1; bus.b_adr = 8'd9; bus.b_din = 32'd200;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_g = (k % 4 == 0) ? 2'b10 : (k % 4 == 2) ? 2'b01 : 2'b00;
            total++; if ({bus.a_gnt, bus.b_gnt} !== exp_g) begin bad++; $display("FAIL alt_gnt%0d: got %b want %b", k, {bus.a_gnt, bus.b_gnt}, exp_g); end
            if (k % 2 == 1) begin
                total++; if (bus.ram_we !== 1'b1 || bus.ram_adr !== ((k % 4 == 1) ? 8'd8 : 8'd9)) begin
                    bad++; $display("FAIL alt_access%0d: we=%b adr=%0d want 1 %0d", k, bus.ram_we, bus.ram_adr, (k % 4 == 1) ? 8 : 9); end
            end
        end
        bus.a_req = 0; bus.b_req = 0;
        @(negedge clk); #1;
    endtask

    task automatic test_reset_in_wait;
        do_reset();
        @(negedge clk); bus.b_req = 1; bus.b_we = 0; bus.b_adr = 8'd3; #1;
        total++; if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin bad++; $display("FAIL rw_gnt: got %b want 01", {bus.a_gnt, bus.b_gnt}); end
        @(negedge clk); bus.b_req = 0;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rw_in_wait: busy got %b want 1", bus.busy); end
        rst_n = 0; #1;
        total++; if ({bus.b_rvalid, bus.a_rvalid, bus.busy, bus.ram_we} !== 4'b0000 || bus.b_rdata !== '0) begin
            bad++; $display("FAIL rw_cleared: rv/busy/we=%b rdata=%h want 0000 0", {bus.b_rvalid, bus.a_rvalid, bus.busy, bus.ram_we}, bus.b_rdata); end
        @(negedge clk); #1;
        total++; if (bus.b_rvalid !== 1'b0) begin bad++; $display("FAIL rw_no_rvalid: got %b want 0", bus.b_rvalid); end
        rst_n = 1;
        bus.a_req = 1; bus.a_we = 0; bus.a_adr = 8'd2;
        bus.b_req = 1; bus.b_we = 0; bus.b_adr = 8'd3; #1;
        total++; if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin bad++; $display("FAIL rw_a_first: got %b want 10", {bus.a_gnt, bus.b_gnt}); end
        @(negedge clk); bus.a_req = 0; bus.b_req = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_lat3;
        logic [2:0] exp_v;
        do_reset();
        // A writes 5 <- 33 and reads it back so a_rdata holds a known value
        @(negedge clk); bus3.a_req = 1; bus3.a_we = 1; bus3.a_adr = 8'd5; bus3.a_din = 32'd33;
        @(negedge clk); bus3.a_req = 0;
        @(negedge clk); bus3.a_req = 1; bus3.a_we = 0; #1;
        total++; if (bus3.a_gnt !== 1'b1) begin bad++; $display("FAIL l3_a_gnt: got %b want 1", bus3.a_gnt); end
        for (int k = 1; k <= 1 + LAT3; k++) begin
            @(negedge clk); bus3.a_req = 0; #1;
            total++; if (bus3.a_rvalid !== (k == 1 + LAT3)) begin bad++; $display("FAIL l3_a_rv%0d: got %b want %b", k, bus3.a_rvalid, (k == 1 + LAT3)); end
        end
        total++; if (bus3.a_rdata !== 32'd33) begin bad++; $display("FAIL l3_a_data: got %0d want 33", bus3.a_rdata); end
        // B writes 4 <- 9, then reads it; A asks again right after B's gnt
        @(negedge clk); bus3.b_req = 1; bus3.b_we = 1; bus3.b_adr = 8'd4; bus3.b_din = 32'd9;
        @(negedge clk); bus3.b_req = 0;
        @(negedge clk); bus3.b_req = 1; bus3.b_we = 0; #1;
        total++; if (bus3.b_gnt !== 1'b1) begin bad++; $display("FAIL l3_b_gnt: got %b want 1", bus3.b_gnt); end
        for (int k = 1; k <= 2 + LAT3; k++) begin
            @(negedge clk); bus3.b_req = 0; bus3.a_req = 1; bus3.a_we = 0; bus3.a_adr = 8'd5; #1;
            exp_v = {(k == 1 + LAT3), (k == 2 + LAT3), (k <= 1 + LAT3)};
            total++; if ({bus3.b_rvalid, bus3.a_gnt, bus3.busy} !== exp_v) begin
                bad++; $display("FAIL l3_b_cycle%0d: rvalid/a_gnt/busy=%b want %b", k, {bus3.b_rvalid, bus3.a_gnt, bus3.busy}, exp_v); end
            if (k == 1 + LAT3) begin
                total++; if (bus3.b_rdata !== 32'd9) begin bad++; $display("FAIL l3_b_data: got %0d want 9", bus3.b_rdata); end
            end
            total++; if (bus3.a_rdata !== 32'd33) begin bad++; $display("FAIL l3_a_kept%0d: got %0d want 33", k, bus3.a_rdata); end
        end
        @(negedge clk); bus3.a_req = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_random;
        logic [DW-1:0] mm [0:7];
        int free_at, wr_due, rd_due, rd_port, cyc;
        logic [DW-1:0] rd_data, exp_ar, exp_br, wr_din;
        logic [AW-1:0] wr_adr;
        bit ptr, a_hold, b_hold, idle, eg_a, eg_b, wb;
        do_reset();
        // preload the window 16..23 so every read has a defined answer
        for (int i = 0; i < 8; i++) begin
            mm[i] = $urandom;
            @(negedge clk); bus.a_req = 1; bus.a_we = 1; bus.a_adr = 8'(16 + i); bus.a_din = mm[i];
            @(negedge clk); bus.a_req = 0;
        end
        @(negedge clk);
        // after the preload A was granted last, so B has priority
        ptr = 1; free_at = 0; wr_due = -1; rd_due = -1; rd_port = 0;
        exp_ar = '0; exp_br = '0; a_hold = 0; b_hold = 0; rd_data = '0;
        for (cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!a_hold) begin
                bus.a_req = ($urandom_range(0, 1) == 1); bus.a_we = ($urandom_range(0, 1) == 1);
                bus.a_adr = 8'(16 + $urandom_range(0, 7)); bus.a_din = $urandom;
            end else if ($urandom_range(0, 7) == 0) bus.a_req = 0;
            if (!b_hold) begin
                bus.b_req = ($urandom_range(0, 1) == 1); bus.b_we = ($urandom_range(0, 1) == 1);
                bus.b_adr = 8'(16 + $urandom_range(0, 7)); bus.b_din = $urandom;
            end else if ($urandom_range(0, 7) == 0) bus.b_req = 0;
            a_hold = bus.a_req; b_hold = bus.b_req;
            #1;
            idle = (cyc >= free_at);
            eg_a = idle && bus.a_req && (!bus.b_req || !ptr);
            eg_b = idle && bus.b_req && !eg_a;
            total++; if ({bus.a_gnt, bus.b_gnt, bus.busy} !== {eg_a, eg_b, !idle}) begin
                bad++; $display("FAIL rnd_gnt c%0d: gnt/busy=%b want %b", cyc, {bus.a_gnt, bus.b_gnt, bus.busy}, {eg_a, eg_b, !idle}); end
            total++; if (bus.ram_we !== (wr_due == cyc)) begin bad++; $display("FAIL rnd_we c%0d: got %b want %b", cyc, bus.ram_we, (wr_due == cyc)); end
            if (wr_due == cyc) begin
                total++; if (bus.ram_adr !== wr_adr || bus.ram_din !== wr_din) begin
                    bad++; $display("FAIL rnd_wdata c%0d: adr=%0d din=%h want %0d %h", cyc, bus.ram_adr, bus.ram_din, wr_adr, wr_din); end
            end
            if (rd_due == cyc) begin
                if (rd_port == 0) exp_ar = rd_data; else exp_br = rd_data;
            end
            total++; if ({bus.a_rvalid, bus.b_rvalid} !== {(rd_due == cyc && rd_port == 0), (rd_due == cyc && rd_port == 1)}) begin
                bad++; $display("FAIL rnd_rvalid c%0d: got %b", cyc, {bus.a_rvalid, bus.b_rvalid}); end
            total++; if (bus.a_rdata !== exp_ar || bus.b_rdata !== exp_br) begin
                bad++; $display("FAIL rnd_rdata c%0d: a=%h b=%h want %h %h", cyc, bus.a_rdata, bus.b_rdata, exp_ar, exp_br); end
            if (eg_a || eg_b) begin
                wb = eg_b;
                ptr = !wb;
                if (wb) b_hold = 0; else a_hold = 0;
                if (wb ? bus.b_we : bus.a_we) begin
                    wr_due = cyc + 1;
                    wr_adr = wb ? bus.b_adr : bus.a_adr;
                    wr_din = wb ? bus.b_din : bus.a_din;
                    mm[int'(wr_adr) - 16] = wr_din;
                    free_at = cyc + 2;
                end else begin
                    rd_due  = cyc + 1 + LAT;
                    rd_port = wb ? 1 : 0;
                    rd_data = mm[int'(wb ? bus.b_adr : bus.a_adr) - 16];
                    free_at = cyc + 2 + LAT;
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_both_writes();
        test_alternation();
        test_reset_in_wait();
        test_lat3();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
